attempt_guard: RTL and testbench
================================

# attempt_guard

Downstream consumer of the password-comparison result in the lock datapath. On each completed entry sequence it samples the match flag, then either grants a timed unlock window or counts a failed attempt. After a configurable number of consecutive failures it enforces a timed lockout. It drives the unlock/lockout flags and a 2-bit status code that the display decoder renders as blank/OPEN/NOPE/LOCK.

## Interface
Parameters:
- MAX_FAILS, default 3: consecutive failures that trigger lockout; legal range 1–7.
- OPEN_CYCLES, default 200: cycles the unlock window is held; must be ≥ 1.
- LOCK_CYCLES, default 1000: cycles the lockout is held; must be ≥ 1.
- TMR_W, default $clog2(max(OPEN_CYCLES, LOCK_CYCLES)+1): hold-timer width.

Ports:
- CLK, input, 1: divided system clock, the same domain as the entry FSM.
- RST_N, input, 1: asynchronous active-low reset.
- CHECK, input, 1: single-cycle strobe meaning an entry sequence has completed.
- MATCH, input, 1: comparison result; sampled only when CHECK=1.
- CREATE, input, 1: password-create mode; while high, CHECK is ignored.
- UNLOCK, output, 1: high during the unlock window.
- LOCKED, output, 1: high during lockout.
- FAILS, output, 3: current consecutive-failure count.
- STATUS, output, 2: display code, 00=blank, 01=OPEN, 10=NOPE, 11=LOCK.

## Operation
- The state machine has four states: IDLE, OPEN, DENY and LOCKOUT.
- A valid check is CHECK=1 and CREATE=0. It is acted on only in IDLE or DENY. In OPEN and LOCKOUT it is ignored, and no failure is counted.
- Valid check with MATCH=1:
  - Next state is OPEN.
  - FAILS clears to 0.
  - The timer loads OPEN_CYCLES-1.
- Valid check with MATCH=0:
  - If FAILS+1 < MAX_FAILS: FAILS increments and the next state is DENY.
  - If FAILS+1 = MAX_FAILS: next state is LOCKOUT, FAILS clears to 0, and the timer loads LOCK_CYCLES-1.
- OPEN and LOCKOUT: the timer decrements by 1 each cycle. In a cycle where the timer is 0, the next state is IDLE. Each state therefore lasts exactly OPEN_CYCLES or LOCK_CYCLES cycles.
- DENY persists until the next valid check. FAILS is retained in DENY.
- CREATE=1 never changes state, FAILS or the timer; it only masks CHECK.
- Outputs are a Moore decode of the registered state:
  - UNLOCK = (state==OPEN).
  - LOCKED = (state==LOCKOUT).
  - STATUS is 00 in IDLE, 01 in OPEN, 10 in DENY, 11 in LOCKOUT.
- Width rules:
  - The FAILS increment never exceeds MAX_FAILS-1, so there is no wrap.
  - The timer never decrements below 0; it holds at 0 outside OPEN and LOCKOUT.

## Timing
- Reset (RST_N low, asynchronous) forces state=IDLE, FAILS=0 and timer=0. Consequently UNLOCK=0, LOCKED=0 and STATUS=00.
- Release of reset is synchronous to the next CLK edge.
- Reset asserted mid-OPEN or mid-LOCKOUT aborts immediately; there is no residual hold.
- Latency: outputs change on the first CLK edge after the cycle in which CHECK is sampled high (1 cycle).
- CHECK held high for several cycles counts once per cycle, but only while the state is IDLE or DENY. Upstream guarantees a single-cycle strobe.
- With MAX_FAILS=1, the first mismatch goes directly from IDLE to LOCKOUT.
- CHECK in the same cycle that OPEN or LOCKOUT expires (timer=0) is ignored. The check is accepted from the following IDLE cycle onward.
- A CREATE rising edge in the same cycle as CHECK masks the check.

## Structure
- The shared package ysnp_pkg holds:
  - the guard_state_t enum: IDLE, OPEN, DENY, LOCKOUT;
  - the STATUS code localparams: ST_BLANK, ST_OPEN, ST_NOPE, ST_LOCK.
- One sub-module, hold_timer. It is a loadable down-counter with inputs CLK, RST_N, load, load_val[TMR_W] and run, and outputs count and zero. It is shared by OPEN and LOCKOUT, since only one is active at a time.
- The top of attempt_guard is the FSM, the FAILS register and the output decode.

## Test plan
Use MAX_FAILS=3, OPEN_CYCLES=4, LOCK_CYCLES=10 unless noted.
- Correct entry: reset, then CHECK with MATCH=1 → next cycle UNLOCK=1 and STATUS=01 for exactly 4 cycles, then IDLE with STATUS=00.
- Two misses then a match: FAILS goes 1 then 2 with STATUS=10; the match gives FAILS=0 and OPEN.
- Three misses → LOCKOUT: LOCKED=1, STATUS=11, FAILS=0 for 10 cycles. A CHECK with MATCH=1 during lockout leaves state and FAILS unchanged.
- CREATE masking: CREATE=1 with CHECK and MATCH=0 pulsed 5 times → FAILS=0 and STATUS=00 throughout.
- Reset mid-LOCKOUT: assert RST_N=0 asynchronously at lockout cycle 5 → LOCKED=0 and STATUS=00 immediately; a CHECK with MATCH=1 after release gives OPEN.
- Boundary case with MAX_FAILS=1: a single miss from IDLE → LOCKOUT on the next cycle, with no DENY.

Source files
------------

// File: rtl/ysnp_pkg.sv
// ysnp_pkg: shared types and constants for the lock datapath.
//   guard_state_t : attempt_guard FSM states (IDLE, OPEN, DENY, LOCKOUT)
//   ST_*          : 2-bit STATUS codes decoded by the display block
//   status_of()   : maps a guard state to its display code
package ysnp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    OPEN    = 2'b01,
    DENY    = 2'b10,
    LOCKOUT = 2'b11
  } guard_state_t;

  localparam logic [1:0] ST_BLANK = 2'b00;
  localparam logic [1:0] ST_OPEN  = 2'b01;
  localparam logic [1:0] ST_NOPE  = 2'b10;
  localparam logic [1:0] ST_LOCK  = 2'b11;

  function automatic logic [1:0] status_of(input guard_state_t s);
    case (s)
      OPEN:    status_of = ST_OPEN;
      DENY:    status_of = ST_NOPE;
      LOCKOUT: status_of = ST_LOCK;
      default: status_of = ST_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/hold_timer.sv
// hold_timer: loadable down-counter used for both the unlock window and the
// lockout hold (only one of them is ever active).
//   CLK, RST_N : clock, asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over run)
//   load_val   : value to load
//   run        : decrement by one per cycle; saturates at zero
//   count      : current counter value
//   zero       : count == 0
module hold_timer #(
  parameter int unsigned W = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (run && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/attempt_guard.sv
// attempt_guard: consumes the password-compare result at the end of each
// entry sequence; grants a timed unlock window on a match, counts
// consecutive failures otherwise, and enforces a timed lockout after
// MAX_FAILS consecutive failures.
//   CLK, RST_N  : divided system clock, asynchronous active-low reset
//   CHECK       : one-cycle strobe, entry sequence complete
//   MATCH       : compare result, sampled only with CHECK
//   CREATE      : password-create mode, masks CHECK
//   UNLOCK      : high in the unlock window
//   LOCKED      : high during lockout
//   FAILS       : consecutive-failure count
//   STATUS      : display code (blank/OPEN/NOPE/LOCK)
//   state_dbg_o : current FSM state, for observation
//   tmr_dbg_o   : current hold-timer value, for observation
//
// Strobe semantics: CHECK has no ready/back-pressure. A cycle with CHECK=1
// and CREATE=0 is a valid check; it is consumed in that same cycle when the
// FSM is in IDLE or DENY and silently dropped in OPEN or LOCKOUT. Results
// appear on the outputs one CLK edge later.
module attempt_guard
  import ysnp_pkg::*;
#(
  parameter int unsigned MAX_FAILS   = 3,
  parameter int unsigned OPEN_CYCLES = 200,
  parameter int unsigned LOCK_CYCLES = 1000,
  parameter int unsigned TMR_W =
    $clog2(((OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES) + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CHECK,
  input  logic             MATCH,
  input  logic             CREATE,
  output logic             UNLOCK,
  output logic             LOCKED,
  output logic [2:0]       FAILS,
  output logic [1:0]       STATUS,
  output guard_state_t     state_dbg_o,
  output logic [TMR_W-1:0] tmr_dbg_o
);

  guard_state_t     state_q, state_d;
  logic [2:0]       fails_q, fails_d;
  logic             unlock_q, locked_q;
  logic [1:0]       status_q;

  logic             valid_check;
  logic             last_fail;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_run;
  logic             tmr_zero;
  logic [TMR_W-1:0] tmr_count;

  assign valid_check = CHECK && !CREATE;
  // Widened by one bit so FAILS+1 is compared without wrap.
  assign last_fail   = (({1'b0, fails_q} + 4'd1) == 4'(MAX_FAILS));
  assign tmr_run     = (state_q == OPEN) || (state_q == LOCKOUT);

  always_comb begin
    state_d  = state_q;
    fails_d  = fails_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE, DENY: begin
        if (valid_check) begin
          if (MATCH) begin
            state_d  = OPEN;
            fails_d  = '0;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(OPEN_CYCLES - 1);
          end else if (last_fail) begin
            state_d  = LOCKOUT;
            fails_d  = '0;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(LOCK_CYCLES - 1);
          end else begin
            state_d = DENY;
            fails_d = fails_q + 3'd1;
          end
        end
      end
      OPEN, LOCKOUT: begin
        // Timer at zero marks the final cycle of the hold.
        if (tmr_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it,
  // which makes them a glitch-free Moore decode of state_q.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      fails_q  <= '0;
      unlock_q <= 1'b0;
      locked_q <= 1'b0;
      status_q <= ST_BLANK;
    end else begin
      state_q  <= state_d;
      fails_q  <= fails_d;
      unlock_q <= (state_d == OPEN);
      locked_q <= (state_d == LOCKOUT);
      status_q <= status_of(state_d);
    end
  end

  hold_timer #(.W(TMR_W)) u_hold_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .run      (tmr_run),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  assign UNLOCK      = unlock_q;
  assign LOCKED      = locked_q;
  assign FAILS       = fails_q;
  assign STATUS      = status_q;
  assign state_dbg_o = state_q;
  assign tmr_dbg_o   = tmr_count;

endmodule

// File: tb/tb_attempt_guard.sv
// Directed bench for attempt_guard. Instance u_dut uses MAX_FAILS=3,
// OPEN_CYCLES=4, LOCK_CYCLES=10; instance u_dut1 uses MAX_FAILS=1.
module tb_attempt_guard;
  import ysnp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         check_i = 1'b0, match_i = 1'b0, create_i = 1'b0;
  logic         unlock, locked;
  logic [2:0]   fails;
  logic [1:0]   status;
  guard_state_t state_dbg;
  logic [3:0]   tmr_dbg;

  logic         check1_i = 1'b0, match1_i = 1'b0, create1_i = 1'b0;
  logic         unlock1, locked1;
  logic [2:0]   fails1;
  logic [1:0]   status1;
  guard_state_t state_dbg1;
  logic [3:0]   tmr_dbg1;

  attempt_guard #(.MAX_FAILS(3), .OPEN_CYCLES(4), .LOCK_CYCLES(10)) u_dut (
    .CLK(clk), .RST_N(rst_n), .CHECK(check_i), .MATCH(match_i),
    .CREATE(create_i), .UNLOCK(unlock), .LOCKED(locked), .FAILS(fails),
    .STATUS(status), .state_dbg_o(state_dbg), .tmr_dbg_o(tmr_dbg)
  );

  attempt_guard #(.MAX_FAILS(1), .OPEN_CYCLES(4), .LOCK_CYCLES(10)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .CHECK(check1_i), .MATCH(match1_i),
    .CREATE(create1_i), .UNLOCK(unlock1), .LOCKED(locked1), .FAILS(fails1),
    .STATUS(status1), .state_dbg_o(state_dbg1), .tmr_dbg_o(tmr_dbg1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];   // packed {UNLOCK, LOCKED, STATUS} per cycle

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare the current {UNLOCK, LOCKED, STATUS} against the queue head.
  task automatic check_flags(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, {unlock, locked, status}, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_check(input logic m);
    check_i = 1'b1;
    match_i = m;
    step();
    check_i = 1'b0;
    match_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state (async, before any clock edge)
    #2;
    check_eq("rst_unlock", unlock, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_status", status, ST_BLANK);
    check_eq("rst_fails",  fails,  0);
    check_eq("rst_status_mf1", status1, ST_BLANK);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Correct entry: OPEN for exactly 4 cycles, then IDLE
    pulse_check(1'b1);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 1'b0, ST_OPEN});
    exp_q.push_back({1'b0, 1'b0, ST_BLANK});
    for (int i = 0; i < 4; i++) begin
      check_flags("open_win");
      step();
    end
    check_flags("open_end");

    // Two misses then a match
    pulse_check(1'b0);
    check_eq("miss1_fails", fails, 1);
    check_eq("miss1_status", status, ST_NOPE);
    pulse_check(1'b0);
    check_eq("miss2_fails", fails, 2);
    check_eq("miss2_status", status, ST_NOPE);
    step(); step();
    check_eq("deny_hold_fails", fails, 2);
    check_eq("deny_hold_status", status, ST_NOPE);
    pulse_check(1'b1);
    check_eq("match_fails", fails, 0);
    check_eq("match_unlock", unlock, 1);
    repeat (4) step();
    check_eq("match_back_idle", status, ST_BLANK);

    // Three misses -> LOCKOUT for 10 cycles; a matching CHECK mid-lockout
    // and another in the expiry cycle are both ignored.
    pulse_check(1'b0);
    pulse_check(1'b0);
    pulse_check(1'b0);
    for (int i = 0; i < 10; i++) exp_q.push_back({1'b0, 1'b1, ST_LOCK});
    exp_q.push_back({1'b0, 1'b0, ST_BLANK});
    for (int i = 0; i < 10; i++) begin
      check_flags("lock_win");
      check_eq("lock_fails", fails, 0);
      if (i == 3 || i == 9) begin
        check_i = 1'b1;
        match_i = 1'b1;
      end
      step();
      check_i = 1'b0;
      match_i = 1'b0;
    end
    check_flags("lock_end");
    check_eq("lock_end_unlock", unlock, 0);

    // CHECK held two cycles counts twice
    check_i = 1'b1;
    match_i = 1'b0;
    step();
    check_eq("held_fails1", fails, 1);
    step();
    check_eq("held_fails2", fails, 2);
    check_i = 1'b0;
    pulse_check(1'b1);
    check_eq("held_clear", fails, 0);
    repeat (4) step();

    // CREATE masks CHECK
    create_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulse_check(1'b0);
      check_eq("create_fails", fails, 0);
      check_eq("create_status", status, ST_BLANK);
    end
    create_i = 1'b0;
    step();

    // Reset in the middle of LOCKOUT aborts immediately
    pulse_check(1'b0);
    pulse_check(1'b0);
    pulse_check(1'b0);
    check_eq("pre_rst_locked", locked, 1);
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_locked", locked, 0);
    check_eq("mid_rst_status", status, ST_BLANK);
    check_eq("mid_rst_fails", fails, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("post_rst_status", status, ST_BLANK);
    pulse_check(1'b1);
    check_eq("post_rst_unlock", unlock, 1);
    check_eq("post_rst_st", status, ST_OPEN);

    // MAX_FAILS=1: a single miss goes straight to LOCKOUT
    check1_i = 1'b1;
    match1_i = 1'b0;
    step();
    check1_i = 1'b0;
    check_eq("mf1_locked", locked1, 1);
    check_eq("mf1_status", status1, ST_LOCK);
    check_eq("mf1_fails", fails1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
